// File: rtl/affine_stream_engine.sv
// Per-frame affine transform engine: loads a ROWS x 4 q-FRAC matrix from an AXIS slave,
// then streams x/y/z points through a fixed-latency saturating transform into a credit-guarded FIFO.
module affine_stream_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int ROWS       = 3,
  parameter int FRAC       = 16,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_keep_matrix,
  input  logic [LANES*DATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic                        s_tlast,
  output logic [ROWS*OUT_WIDTH-1:0]   m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        load_err
);

  localparam int MAT_WORDS = ROWS * 4;
  localparam int MAT_BEATS = (MAT_WORDS + LANES - 1) / LANES;
  localparam int BEAT_W    = (MAT_BEATS > 1) ? $clog2(MAT_BEATS) : 1;
  localparam int ACC_W     = 2 * DATA_WIDTH + 2;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam int RES_W     = ROWS * OUT_WIDTH;

  if (LANES < 4 || ROWS < 1 || ROWS > 8 || PIPE_LAT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FRAC >= DATA_WIDTH || OUT_WIDTH > ACC_W) begin : g_param_check
    $error("affine_stream_engine: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic                          mat_valid_q, mat_valid_d;
  logic                          load_err_q, load_err_d;
  logic signed [DATA_WIDTH-1:0]  mat_q [MAT_WORDS];

  logic [PIPE_LAT-1:0]           vld_q;
  logic [PIPE_LAT-1:0]           last_q;
  logic signed [DATA_WIDTH-1:0]  x_q, y_q, z_q;
  logic [RES_W-1:0]              res_q [1:PIPE_LAT-1];
  logic [RES_W-1:0]              res_s;

  logic [RES_W:0]                fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_q, rd_q;
  logic [PTR_W:0]                cnt_q;

  logic                          ready_s, s_hand_s, m_hand_s, push_s, mat_we_s;
  logic [CNT_W-1:0]              occupancy_s;
  logic [RES_W:0]                head_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [PIPE_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PIPE_LAT; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Clamp a full-precision sum into signed OUT_WIDTH; in range iff all bits above the sign agree.
  function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-OUT_WIDTH:0] top;
    top = a[ACC_W-1:OUT_WIDTH-1];
    if (top == '0 || top == '1) return a[OUT_WIDTH-1:0];
    else if (a[ACC_W-1])        return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                        return {1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

  assign occupancy_s = CNT_W'(cnt_q) + popcount(vld_q);
  assign s_tready    = ready_s & ~areset;
  assign s_hand_s    = s_tvalid & s_tready;
  assign m_hand_s    = m_tvalid & m_tready;
  assign push_s      = vld_q[PIPE_LAT-1];
  assign head_s      = fifo_mem_q[rd_q];
  assign m_tvalid    = (cnt_q != '0);
  assign m_tdata     = m_tvalid ? head_s[RES_W-1:0] : '0;
  assign m_tlast     = m_tvalid & head_s[RES_W];
  assign frame_done  = m_hand_s & m_tlast;
  assign busy        = (state_q != ST_LOAD);
  assign load_err    = load_err_q;

  // Slave ready: unconditional while loading, credit-limited while streaming (registered count only).
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_LOAD:   ready_s = 1'b1;
      ST_STREAM: ready_s = (occupancy_s < CNT_W'(FIFO_DEPTH));
      default:   ready_s = 1'b0;
    endcase
  end

  // Next-state logic for the load/stream/drain sequencer.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mat_valid_d = mat_valid_q;
    load_err_d  = load_err_q;
    mat_we_s    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (s_hand_s && s_tlast) begin
          load_err_d = 1'b1;
          beat_d     = '0;
        end else if (s_hand_s) begin
          mat_we_s = 1'b1;
          if (beat_q == BEAT_W'(MAT_BEATS - 1)) begin
            mat_valid_d = 1'b1;
            beat_d      = '0;
            state_d     = ST_STREAM;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      ST_STREAM: begin
        if (s_hand_s && s_tlast) state_d = ST_DRAIN;
        else                     state_d = ST_STREAM;
      end
      ST_DRAIN: begin
        if (m_hand_s && m_tlast) begin
          if (cfg_keep_matrix && mat_valid_q) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_LOAD;
            beat_d  = '0;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Sequencer state and matrix storage.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_LOAD;
      beat_q      <= '0;
      mat_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int w = 0; w < MAT_WORDS; w++) mat_q[w] <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mat_valid_q <= mat_valid_d;
      load_err_q  <= load_err_d;
      for (int w = 0; w < MAT_WORDS; w++) begin
        if (mat_we_s && beat_q == BEAT_W'(w / LANES))
          mat_q[w] <= s_tdata[(w % LANES)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Full-precision row sums from the captured point; every term is already q FRAC.
  always_comb begin
    logic signed [ACC_W-1:0] xe, ye, ze, acc;
    res_s = '0;
    xe = ACC_W'(x_q);
    ye = ACC_W'(y_q);
    ze = ACC_W'(z_q);
    for (int r = 0; r < ROWS; r++) begin
      acc = ACC_W'(mat_q[r*4+0]) * xe + ACC_W'(mat_q[r*4+1]) * ye +
            ACC_W'(mat_q[r*4+2]) * ze + ACC_W'(mat_q[r*4+3]);
      res_s[r*OUT_WIDTH +: OUT_WIDTH] = sat(acc);
    end
  end

  // Non-stalling pipeline: capture, compute, then PIPE_LAT-2 delay stages into the FIFO.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q  <= '0;
      last_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      for (int k = 1; k < PIPE_LAT; k++) res_q[k] <= '0;
    end else begin
      vld_q  <= {vld_q[PIPE_LAT-2:0], s_hand_s & (state_q == ST_STREAM)};
      last_q <= {last_q[PIPE_LAT-2:0], s_tlast};
      x_q    <= s_tdata[0*DATA_WIDTH +: DATA_WIDTH];
      y_q    <= s_tdata[1*DATA_WIDTH +: DATA_WIDTH];
      z_q    <= s_tdata[2*DATA_WIDTH +: DATA_WIDTH];
      res_q[1] <= res_s;
      for (int k = 2; k < PIPE_LAT; k++) res_q[k] <= res_q[k-1];
    end
  end

  // Output FIFO; credit throttling guarantees a push never meets a full FIFO without a pop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_q] <= {last_q[PIPE_LAT-1], res_q[PIPE_LAT-1]};
        wr_q             <= wr_q + PTR_W'(1);
      end
      if (m_hand_s) rd_q <= rd_q + PTR_W'(1);
      case ({push_s, m_hand_s})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_stream_engine.sv
// Directed bench for affine_stream_engine: matrix load, transform, saturation, backpressure,
// keep-matrix, load error and mid-frame reset, all against hand-computed results.
module tb_affine_stream_engine;

  localparam int BUDGET = 200;

  logic         aclk = 1'b0;
  logic         areset, cfg_keep_matrix, s_tvalid, s_tlast, m_tready;
  logic [127:0] s_tdata;
  logic         s_tready, m_tvalid, m_tlast, busy, frame_done, load_err;
  logic [95:0]  m_tdata;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int acc_cnt = 0;
  logic [31:0] mw [12];

  always #5 aclk = ~aclk;

  affine_stream_engine #(
    .DATA_WIDTH(32), .OUT_WIDTH(32), .LANES(4), .ROWS(3),
    .FRAC(16), .PIPE_LAT(4), .FIFO_DEPTH(8)
  ) dut (
    .aclk(aclk), .areset(areset), .cfg_keep_matrix(cfg_keep_matrix),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .frame_done(frame_done), .load_err(load_err)
  );

  always @(posedge aclk) if (frame_done) fd_cnt <= fd_cnt + 1;
  always @(posedge aclk) if (s_tvalid && s_tready && busy) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] pt(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {32'h0, z, y, x};
  endfunction

  function automatic logic [95:0] rs(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    return {r2, r1, r0};
  endfunction

  // Must be called just after a rising edge.
  task automatic send(input logic [127:0] d, input logic last);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    chk("send_timeout", s_tready, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [95:0] exp_d, input logic exp_l);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge aclk);
      if (m_tvalid) break;
    end
    chk({tag, "_vld"}, m_tvalid, 1'b1);
    m_tready = 1'b1;
    #1;
    chk({tag, "_dat"}, m_tdata, exp_d);
    chk({tag, "_last"}, m_tlast, exp_l);
    chk({tag, "_fdone"}, frame_done, exp_l);
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
  endtask

  task automatic load_mat();
    for (int b = 0; b < 3; b++) send({mw[4*b+3], mw[4*b+2], mw[4*b+1], mw[4*b]}, 1'b0);
  endtask

  task automatic clr_mat();
    for (int i = 0; i < 12; i++) mw[i] = 32'h0;
  endtask

  task automatic set_ident();
    clr_mat();
    mw[0]  = 32'h0001_0000;
    mw[5]  = 32'h0001_0000;
    mw[10] = 32'h0001_0000;
  endtask

  function automatic logic [127:0] bp_pt(input int i);
    return pt(32'(i + 1), 32'(-(i + 1)), 32'(100 + i));
  endfunction

  function automatic logic [95:0] bp_res(input int i);
    logic [31:0] x, y, z;
    x = 32'(i + 1);
    y = 32'(-(i + 1));
    z = 32'(100 + i);
    return rs(x << 16, y << 16, z << 16);
  endfunction

  initial begin
    int lat, fd0, acc0, stale;
    areset = 1'b1; cfg_keep_matrix = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; m_tready = 1'b0;
    clr_mat();
    repeat (2) step();
    @(negedge aclk);
    chk("rst_rdy_low", s_tready, 1'b0);
    step();
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_mvalid", m_tvalid, 1'b0);
    chk("rst_mlast", m_tlast, 1'b0);
    chk("rst_mdata", m_tdata, 96'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fdone", frame_done, 1'b0);
    chk("rst_lerr", load_err, 1'b0);
    chk("rst_load_rdy", s_tready, 1'b1);
    step();

    // Identity matrix, single-point frame, latency check
    set_ident();
    load_mat();
    chk("id_busy", busy, 1'b1);
    fd0 = fd_cnt;
    send(pt(32'd3, 32'hFFFF_FFFB, 32'd7), 1'b1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (m_tvalid) break;
      lat++;
    end
    chk("id_latency", 32'(lat), 32'd4);
    recv("id", rs(32'h0003_0000, 32'hFFFB_0000, 32'h0007_0000), 1'b1);
    chk("id_fd_once", 32'(fd_cnt - fd0), 32'd1);
    chk("id_busy_after", busy, 1'b0);

    // Translation
    set_ident();
    mw[3] = 32'h0000_8000;
    mw[7] = 32'hFFFF_0000;
    load_mat();
    send(pt(32'd1, 32'd1, 32'd1), 1'b1);
    recv("tr", rs(32'h0001_8000, 32'h0000_0000, 32'h0001_0000), 1'b1);

    // Saturation both ways
    clr_mat();
    mw[0] = 32'h7FFF_FFFF;
    load_mat();
    send(pt(32'h7FFF_FFFF, 32'h0, 32'h0), 1'b0);
    send(pt(32'h8000_0000, 32'h0, 32'h0), 1'b1);
    recv("sat_max", rs(32'h7FFF_FFFF, 32'h0, 32'h0), 1'b0);
    recv("sat_min", rs(32'h8000_0000, 32'h0, 32'h0), 1'b1);

    // Backpressure: 8 credits, then stall, then drain 20 in order
    set_ident();
    load_mat();
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) send(bp_pt(i), 1'b0);
    s_tdata = bp_pt(8); s_tlast = 1'b0; s_tvalid = 1'b1;
    repeat (20) @(negedge aclk);
    chk("bp_stall_rdy", s_tready, 1'b0);
    chk("bp_accepted", 32'(acc_cnt - acc0), 32'd8);
    chk("bp_head_hold", m_tdata, bp_res(0));
    step();
    fork
      begin
        for (int i = 8; i < 20; i++) send(bp_pt(i), (i == 19));
      end
      begin
        for (int j = 0; j < 20; j++) recv($sformatf("bp%0d", j), bp_res(j), (j == 19));
      end
    join
    chk("bp_total", 32'(acc_cnt - acc0), 32'd20);

    // Keep-matrix on: frame 2 streams with frame-1 matrix
    clr_mat();
    mw[0] = 32'h0002_0000; mw[3] = 32'h0001_0000; mw[5] = 32'h0001_0000; mw[10] = 32'h0001_0000;
    cfg_keep_matrix = 1'b1;
    load_mat();
    send(pt(32'd1, 32'd2, 32'd3), 1'b0);
    send(pt(32'd4, 32'd5, 32'd6), 1'b1);
    recv("k1a", rs(32'h0003_0000, 32'h0002_0000, 32'h0003_0000), 1'b0);
    recv("k1b", rs(32'h0009_0000, 32'h0005_0000, 32'h0006_0000), 1'b1);
    chk("keep_busy", busy, 1'b1);
    send(pt(32'd1, 32'd1, 32'd1), 1'b0);
    send(pt(32'd2, 32'd2, 32'd2), 1'b1);
    recv("k2a", rs(32'h0003_0000, 32'h0001_0000, 32'h0001_0000), 1'b0);
    cfg_keep_matrix = 1'b0;
    recv("k2b", rs(32'h0005_0000, 32'h0002_0000, 32'h0002_0000), 1'b1);
    chk("keep_off_busy", busy, 1'b0);

    // Keep-matrix off: frame-2 beats become matrix words
    load_mat();
    send(pt(32'd1, 32'd2, 32'd3), 1'b0);
    send(pt(32'd4, 32'd5, 32'd6), 1'b1);
    recv("n1a", rs(32'h0003_0000, 32'h0002_0000, 32'h0003_0000), 1'b0);
    recv("n1b", rs(32'h0009_0000, 32'h0005_0000, 32'h0006_0000), 1'b1);
    send(pt(32'd1, 32'd1, 32'd1), 1'b0);
    send(pt(32'd2, 32'd2, 32'd2), 1'b0);
    chk("nokeep_loading", busy, 1'b0);
    send({32'd5, 32'd0, 32'd0, 32'd0}, 1'b0);
    chk("nokeep_loaded", busy, 1'b1);
    send(pt(32'h0001_0000, 32'd0, 32'd0), 1'b1);
    recv("n2", rs(32'h0001_0000, 32'h0002_0000, 32'h0000_0005), 1'b1);

    // tlast during LOAD: beat discarded, full reload needed
    chk("err_pre", load_err, 1'b0);
    set_ident();
    send({mw[3], mw[2], mw[1], mw[0]}, 1'b0);
    send({mw[7], mw[6], mw[5], mw[4]}, 1'b1);
    chk("err_set", load_err, 1'b1);
    chk("err_busy", busy, 1'b0);
    send({mw[3], mw[2], mw[1], mw[0]}, 1'b0);
    send({mw[7], mw[6], mw[5], mw[4]}, 1'b0);
    chk("err_reload_pending", busy, 1'b0);
    send({mw[11], mw[10], mw[9], mw[8]}, 1'b0);
    chk("err_reload_done", busy, 1'b1);
    send(pt(32'd3, 32'd4, 32'd5), 1'b1);
    recv("err_res", rs(32'h0003_0000, 32'h0004_0000, 32'h0005_0000), 1'b1);
    chk("err_sticky", load_err, 1'b1);

    // Reset mid-stream with 3 points in flight
    load_mat();
    send(pt(32'd1, 32'd1, 32'd1), 1'b0);
    send(pt(32'd2, 32'd2, 32'd2), 1'b0);
    send(pt(32'd3, 32'd3, 32'd3), 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    chk("mrst_rdy_low", s_tready, 1'b0);
    step();
    chk("mrst_mvalid", m_tvalid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_lerr", load_err, 1'b0);
    areset = 1'b0;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (m_tvalid) stale++;
    end
    chk("mrst_no_stale", 32'(stale), 32'd0);
    chk("mrst_load_rdy", s_tready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/affine_stream_engine.md
Name: affine_stream_engine

Overview:
- Parametrised successor to the fixed 3x4 matrix-load/stream front end, used ahead of the CORDIC/kernel stages.
- Per frame, loads an ROWS x 4 affine matrix (signed q FRAC) from an AXIS slave, then streams points through an internal fixed-latency affine transform.
- Results go to an AXIS master with full m_tready backpressure, credit-based input throttling, frame-level tlast propagation and an optional keep-matrix mode.

Parameters:
- DATA_WIDTH, 32, width of each input lane and each matrix coefficient (signed).
- OUT_WIDTH, 32, width of each output row result (signed, q FRAC).
- LANES, 4, input lanes per beat; must be >= 4.
- ROWS, 3, matrix rows = output channels (1..8).
- FRAC, 16, fractional bits of coefficients and results.
- PIPE_LAT, 4, compute pipeline depth in cycles (>= 2).
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_keep_matrix  in  1  1 = reuse the current matrix for the next frame (sampled at end of DRAIN).
- s_tdata  in  LANES*DATA_WIDTH  lane0 in LSBs.
- s_tvalid  in  1  AXIS slave valid.
- s_tready  out  1  AXIS slave ready.
- s_tlast  in  1  last point of frame.
- m_tdata  out  ROWS*OUT_WIDTH  row0 in LSBs.
- m_tvalid  out  1  AXIS master valid.
- m_tready  in  1  AXIS master ready.
- m_tlast  out  1  last result of frame.
- busy  out  1  high in STREAM or DRAIN.
- frame_done  out  1  one-cycle pulse on the m_tlast handshake.
- load_err  out  1  sticky; set when s_tlast is accepted during LOAD; cleared only by areset.

Behaviour:
- Reset (areset=1 at a rising edge): state LOAD, mat_idx=0, mat_valid=0, pipeline valids cleared, FIFO emptied. Outputs: s_tready=0 for that cycle then per rules; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, frame_done=0, load_err=0. Reset mid-frame discards all in-flight data.
- Handshake: s_hand = s_tvalid & s_tready; m_hand = m_tvalid & m_tready. m_tdata and m_tlast hold stable while m_tvalid & !m_tready.
- MAT_WORDS = ROWS*4; MAT_BEATS = ceil(MAT_WORDS/LANES).
- LOAD:
  - s_tready=1.
  - Each s_hand writes lanes 0..LANES-1 to mat[mat_idx..mat_idx+LANES-1]; words at index >= MAT_WORDS are dropped. Then mat_idx += LANES.
  - Coefficient mapping: mat[r*4+c] = a[r][c].
  - When the beat completing MAT_BEATS is accepted: mat_valid=1, mat_idx=0, go to STREAM.
  - If an accepted LOAD beat has s_tlast=1: beat discarded, load_err=1, mat_idx=0, stay in LOAD, mat_valid unchanged.
- STREAM:
  - Lanes 0..2 = signed x, y, z (q0); lanes >= 3 ignored.
  - res[r] = a[r][0]*x + a[r][1]*y + a[r][2]*z + a[r][3], computed at full precision (2*DATA_WIDTH+2 bits), result q FRAC.
  - Result saturated to signed OUT_WIDTH: max 2^(OUT_WIDTH-1)-1, min -2^(OUT_WIDTH-1). Never wraps.
  - Non-stalling pipeline: a beat accepted at edge t is written to the FIFO at edge t+PIPE_LAT, and m_tvalid can rise after edge t+PIPE_LAT (FIFO empty, no backpressure). tlast travels with the data.
  - Credit rule: s_tready = (fifo_count + inflight) < FIFO_DEPTH, so the FIFO never overflows. A simultaneous FIFO pop does not grant credit in the same cycle.
  - On an s_hand with s_tlast=1, go to DRAIN.
- DRAIN:
  - s_tready=0; the pipeline and FIFO empty out.
  - On the m_hand carrying m_tlast: frame_done=1 for one cycle.
  - Next state: STREAM if cfg_keep_matrix & mat_valid, else LOAD with mat_idx=0.
- Simultaneous FIFO push and pop when full or empty is legal; count is unchanged.
- busy = (state != LOAD).

Test Plan:
- Identity load: a00=a11=a22=0x00010000, all other coefficients 0, ROWS=3. Point (3,-5,7) with tlast -> m_tdata rows 0x00030000, 0xFFFB0000, 0x00070000; m_tlast=1; first m_tvalid after edge t+PIPE_LAT; frame_done pulses once.
- Translation: a03=0x00008000, a13=0xFFFF0000, identity otherwise. Point (1,1,1) -> rows 0x00018000, 0x00000000, 0x00010000.
- Saturation: a00=0x7FFFFFFF, x=0x7FFFFFFF -> row0=0x7FFFFFFF. a00=0x7FFFFFFF, x=0x80000000 -> row0=0x80000000.
- Backpressure: hold m_tready=0 and stream 20 points -> exactly FIFO_DEPTH points accepted before s_tready=0. Release m_tready -> all 20 results delivered in order, none lost or duplicated, tlast only on the 20th.
- Keep-matrix mode: cfg_keep_matrix=1; frame 1 (load + 2 points), then frame 2 (2 points only) -> frame 2 results use the frame-1 matrix. Same sequence with cfg_keep_matrix=0 -> frame 2's first beats are consumed as matrix words.
- Errors and reset: s_tlast on the 2nd LOAD beat -> load_err=1 and a full reload is required. areset asserted in STREAM with 3 points in flight -> next cycle m_tvalid=0, busy=0, load_err=0, and no stale results appear afterwards.
